// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line levels.
// Used by uart_tx_serializer and the planned uart_rx.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      CLEANUP = 3'd5
   } uart_state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Shared between the transmitter and the receiver.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 217
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = (cnt_q == CNT_LAST);

   // Wrapping on the tick keeps every bit period aligned to its own entry edge.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter, LSB first, idle-high line, registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 217,
   parameter int STOP_BITS    = 1
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_Tx_DV,
   input  logic [7:0] i_Tx_Byte,
   output logic       o_Tx_Active,
   output logic       o_Tx_Serial,
   output logic       o_Tx_Done
);

   localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
   localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_t state_q, state_d;
   logic [7:0]  byte_q, byte_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        stop_cnt_q, stop_cnt_d;
   logic        serial_q, serial_d;
   logic        active_q, active_d;
   logic        done_q, done_d;
   logic        baud_clear;
   logic        baud_tick;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_tick (
      .clk_i   (i_Clk),
      .rst_n_i (i_Rst_n),
      .clear_i (baud_clear),
      .tick_o  (baud_tick)
   );

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q    <= IDLE;
         byte_q     <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= '0;
         serial_q   <= LINE_IDLE;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         serial_q   <= serial_d;
         active_q   <= active_d;
         done_q     <= done_d;
      end
   end

   // Line level is computed one step ahead so each bit appears on its entry edge.
   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      serial_d   = serial_q;
      active_d   = active_q;
      done_d     = 1'b0;
      baud_clear = 1'b0;

      case (state_q)
         IDLE: begin
            baud_clear = 1'b1;
            serial_d   = LINE_IDLE;
            active_d   = 1'b0;
            bit_idx_d  = '0;
            stop_cnt_d = '0;
            if (i_Tx_DV) begin
               byte_d   = i_Tx_Byte;
               state_d  = START;
               serial_d = START_LEVEL;
               active_d = 1'b1;
            end
         end

         START: begin
            if (baud_tick) begin
               state_d   = DATA;
               bit_idx_d = '0;
               serial_d  = byte_q[0];
            end
         end

         DATA: begin
            if (baud_tick) begin
               if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d  = PARITY;
                  serial_d = ^byte_q;
`else
                  state_d  = STOP;
                  serial_d = LINE_IDLE;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  serial_d  = byte_q[bit_idx_q + 3'd1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_tick) begin
               state_d  = STOP;
               serial_d = LINE_IDLE;
            end
         end
`endif

         STOP: begin
            serial_d = LINE_IDLE;
            if (baud_tick) begin
               if (stop_cnt_q == STOP_LAST) begin
                  state_d    = CLEANUP;
                  stop_cnt_d = '0;
                  done_d     = 1'b1;
                  active_d   = 1'b0;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end

         CLEANUP: begin
            baud_clear = 1'b1;
            serial_d   = LINE_IDLE;
            active_d   = 1'b0;
            state_d    = IDLE;
         end

         default: begin
            baud_clear = 1'b1;
            serial_d   = LINE_IDLE;
            active_d   = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   assign o_Tx_Active = active_q;
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=4 (STOP_BITS=2 with UART_TX_PARITY_EN).
module tb_uart_tx_serializer;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int TB_STOP  = 2;
   localparam int PAR_BITS = 1;
`else
   localparam int TB_STOP  = 1;
   localparam int PAR_BITS = 0;
`endif
   localparam int FRAME_BITS = 1 + 8 + PAR_BITS + TB_STOP;
   localparam int FRAME_CYC  = FRAME_BITS * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dv_dir;
   logic [7:0] byte_dir;
   logic       loop_en;
   logic       dv_reg;
   logic [7:0] byte_cnt;
   logic       tx_dv;
   logic [7:0] tx_byte;
   logic       act, ser, done;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign tx_dv   = loop_en ? dv_reg   : dv_dir;
   assign tx_byte = loop_en ? byte_cnt : byte_dir;

   uart_tx_serializer #(
      .CLKS_PER_BIT(CPB),
      .STOP_BITS   (TB_STOP)
   ) dut (
      .i_Clk       (clk),
      .i_Rst_n     (rst_n),
      .i_Tx_DV     (tx_dv),
      .i_Tx_Byte   (tx_byte),
      .o_Tx_Active (act),
      .o_Tx_Serial (ser),
      .o_Tx_Done   (done)
   );

   // Upstream byte counter: DV registered from !Active, so it lags Active by a cycle.
   always @(posedge clk) begin
      if (!loop_en) begin
         dv_reg   <= 1'b0;
         byte_cnt <= 8'd0;
      end else begin
         if (dv_reg && !act && byte_cnt < 8'd4) byte_cnt <= byte_cnt + 8'd1;
         dv_reg <= !act && (byte_cnt < 8'd4);
      end
   end

   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " serial"}, 8'(ser), 8'd1);
      chk({tag, " active"}, 8'(act), 8'd0);
      chk({tag, " done"},   8'(done), 8'd0);
   endtask

   task automatic accept(input logic [7:0] b);
      byte_dir = b;
      dv_dir   = 1'b1;
      step();
      dv_dir   = 1'b0;
   endtask

   // Checks samples from the accepting edge onward; returns early at stop_at.
   task automatic check_frame(input logic [7:0] b, input logic [7:0] new_b,
                              input int stop_at, input string name);
      for (int i = 0; i < FRAME_CYC; i++) begin
         if (i == stop_at) return;
         if (i == 6) byte_dir = new_b;
         chk($sformatf("%s serial c%0d", name, i), 8'(ser), 8'(frame_bit(b, i / CPB)));
         chk($sformatf("%s active c%0d", name, i), 8'(act), 8'd1);
         chk($sformatf("%s done c%0d", name, i),   8'(done), 8'd0);
         step();
      end
      chk({name, " end done"},   8'(done), 8'd1);
      chk({name, " end active"}, 8'(act),  8'd0);
      chk({name, " end serial"}, 8'(ser),  8'd1);
      step();
      chk_idle({name, " cleanup"});
   endtask

   logic act_r[$];
   logic ser_r[$];
   logic dn_r[$];
   int   starts[$];
   int   n_done;

   initial begin
      rst_n    = 1'b0;
      dv_dir   = 1'b1;
      byte_dir = 8'h55;
      loop_en  = 1'b0;

      // Reset held with DV asserted: nothing may start.
      for (int i = 0; i < 3; i++) begin
         step();
         chk_idle($sformatf("reset c%0d", i));
      end
      // First edge with reset released accepts the pending DV.
      rst_n = 1'b1;
      step();
      dv_dir = 1'b0;
      check_frame(8'h55, 8'h55, FRAME_CYC, "post-reset 55");

      accept(8'hA5);
      check_frame(8'hA5, 8'hA5, FRAME_CYC, "A5");

      // Back-to-back frames driven by the registered upstream model.
      loop_en = 1'b1;
      for (int i = 0; i < 4 * (FRAME_CYC + 3) + 10; i++) begin
         act_r.push_back(act);
         ser_r.push_back(ser);
         dn_r.push_back(done);
         step();
      end
      loop_en = 1'b0;
      n_done  = 0;
      for (int i = 0; i < act_r.size(); i++) begin
         if (dn_r[i]) n_done++;
         if (act_r[i] && (i == 0 || !act_r[i-1])) starts.push_back(i);
      end
      chk("loop frame count", 8'(starts.size()), 8'd4);
      chk("loop done count",  8'(n_done), 8'd4);
      for (int f = 0; f < starts.size() && f < 4; f++) begin
         int s;
         s = starts[f];
         chk($sformatf("loop f%0d gap serial", f), 8'(s > 0 ? ser_r[s-1] : 1'b0), 8'd1);
         chk($sformatf("loop f%0d gap active", f), 8'(s > 0 ? act_r[s-1] : 1'b1), 8'd0);
         for (int b = 0; b < FRAME_BITS; b++) begin
            int k;
            k = s + b * CPB + 2;
            chk($sformatf("loop f%0d bit%0d", f, b),
                8'(k < ser_r.size() ? ser_r[k] : 1'bx), 8'(frame_bit(8'(f), b)));
         end
      end
      step();
      step();
      chk_idle("loop quiet");

      // Input byte changes while DATA is in flight.
      accept(8'hFF);
      check_frame(8'hFF, 8'h00, FRAME_CYC, "FF hold");

      // Reset during data bit 3 of 0x0F.
      accept(8'h0F);
      check_frame(8'h0F, 8'h0F, 4 * CPB + 1, "0F pre-abort");
      rst_n = 1'b0;
      step();
      chk_idle("abort edge");
      rst_n = 1'b1;
      step();
      chk_idle("abort release");
      accept(8'h0F);
      check_frame(8'h0F, 8'h0F, FRAME_CYC, "0F after abort");

`ifdef UART_TX_PARITY_EN
      accept(8'h07);
      check_frame(8'h07, 8'h07, FRAME_CYC, "parity 07");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
